// File: rtl/uart_tx_cfg_pkg.sv
// Shared UART types: parity modes, transmitter FSM states and a counter width helper.
// Also used by the planned receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Word handshake between a byte source (master) and the UART transmitter (slave).
interface uart_tx_cfg_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_ready;

    modport master (output i_data, output i_valid, input o_ready);
    modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLK_DIV-1 while enabled and flags the last count.
// Held at zero while disabled so every frame starts on a fresh bit boundary.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);
    localparam int               CNT_W    = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign o_tick = i_en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!i_en || o_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, DATA_W data bits LSB first,
// optional parity bit and 1 or 2 stop bits, each bit held CLK_DIV clocks.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int      CLK_DIV   = 16,
    parameter int      DATA_W    = 8,
    parameter parity_e PARITY    = PAR_NONE,
    parameter int      STOP_BITS = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_tx_cfg_if.slave  tx_if,
    output logic          o_uart_tx,
    output logic          o_busy,
    output logic          o_done
);
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("uart_tx_cfg: CLK_DIV must be >= 2");
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_cfg: DATA_W must be in 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam int               IDX_W      = cnt_width(DATA_W);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_W - 1);
    localparam logic             STOP_LAST  = (STOP_BITS == 2);
    localparam bit               HAS_PARITY = (PARITY != PAR_NONE);

    tx_state_e         state_q;
    logic [DATA_W-1:0] shift_q;
    logic [IDX_W-1:0]  bit_idx_q;
    logic              stop_idx_q;
    logic              par_q;
    logic              par_d;
    logic              tx_q;

    logic tick;
    logic last_stop_clk;
    logic ready;
    logic accept;

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (state_q != ST_IDLE),
        .o_tick (tick)
    );

    // The final stop clock doubles as an accept slot so frames can run back to back.
    assign last_stop_clk = (state_q == ST_STOP) && tick && (stop_idx_q == STOP_LAST);
    assign ready         = ((state_q == ST_IDLE) || last_stop_clk) && !i_rst;
    assign accept        = tx_if.i_valid && ready;
    assign par_d         = (PARITY == PAR_ODD) ? ~^tx_if.i_data : ^tx_if.i_data;

    assign tx_if.o_ready = ready;
    assign o_uart_tx     = tx_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = last_stop_clk;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shift_q <= tx_if.i_data;
                        par_q   <= par_d;
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx_q == IDX_LAST) begin
                            if (HAS_PARITY) begin
                                tx_q    <= par_q;
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q       <= 1'b1;
                                stop_idx_q <= 1'b0;
                                state_q    <= ST_STOP;
                            end
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        tx_q       <= 1'b1;
                        stop_idx_q <= 1'b0;
                        state_q    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (last_stop_clk) begin
                        if (accept) begin
                            shift_q <= tx_if.i_data;
                            par_q   <= par_d;
                            tx_q    <= 1'b0;
                            state_q <= ST_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end else if (tick) begin
                        stop_idx_q <= 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed plus random frames on several transmitter configurations, each line
// sample compared against a per-clock frame model built from the bit layout.
module tb_uart_tx_cfg;
    import uart_pkg::*;

    localparam int N = 5;
    localparam int CD [N] = '{4, 4, 4, 4, 2};
    localparam int DW [N] = '{8, 8, 8, 7, 9};
    localparam int PM [N] = '{0, 1, 2, 0, 2};
    localparam int SB [N] = '{1, 1, 1, 2, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] data_r  [N];
    logic       valid_r [N];
    logic       ready_w [N];
    logic       tx_w    [N];
    logic       busy_w  [N];
    logic       done_w  [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        uart_tx_cfg_if #(.DATA_W(DW[gi])) bus ();
        assign bus.i_data  = data_r[gi][DW[gi]-1:0];
        assign bus.i_valid = valid_r[gi];
        assign ready_w[gi] = bus.o_ready;

        uart_tx_cfg #(
            .CLK_DIV   (CD[gi]),
            .DATA_W    (DW[gi]),
            .PARITY    (parity_e'(PM[gi])),
            .STOP_BITS (SB[gi])
        ) dut (
            .i_clk     (clk),
            .i_rst     (rst),
            .tx_if     (bus),
            .o_uart_tx (tx_w[gi]),
            .o_busy    (busy_w[gi]),
            .o_done    (done_w[gi])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic string tg(input int k, input int c, input string name);
        return $sformatf("k%0d c%0d %s", k, c, name);
    endfunction

    function automatic int frame_len(input int k);
        return (1 + DW[k] + ((PM[k] != 0) ? 1 : 0) + SB[k]) * CD[k];
    endfunction

    // Expected line level in clock c (1-based) after the accepting edge.
    function automatic logic exp_line(input int k, input logic [8:0] d, input int c);
        int         b;
        logic [8:0] m;
        b = (c - 1) / CD[k];
        m = d & ((9'h1 << DW[k]) - 9'h1);
        if (b == 0) return 1'b0;
        if (b <= DW[k]) return d[b-1];
        if (PM[k] != 0 && b == DW[k] + 1)
            return logic'(($countones(m) % 2) == 1) ^ logic'(PM[k] == 2);
        return 1'b1;
    endfunction

    // Starts at a falling edge with the transmitter ready. rst_clk / noise_clk
    // select the clock where reset or a stray valid pulse is injected.
    task automatic send(input int k, input logic [8:0] d, input bit chain,
                        input logic [8:0] d_next, input int rst_clk, input int noise_clk);
        int len;
        len = frame_len(k);
        data_r[k]  = d;
        valid_r[k] = 1'b1;
        chk(tg(k, 0, "ready_before_accept"), 32'(ready_w[k]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (chain) begin
            data_r[k] = d_next;
        end else begin
            valid_r[k] = 1'b0;
            data_r[k]  = 9'($urandom);
        end
        for (int c = 1; c <= len; c++) begin
            chk(tg(k, c, "tx"),    32'(tx_w[k]),   32'(exp_line(k, d, c)));
            chk(tg(k, c, "done"),  32'(done_w[k]), 32'(c == len));
            chk(tg(k, c, "busy"),  32'(busy_w[k]), 32'd1);
            chk(tg(k, c, "ready"), 32'(ready_w[k]), 32'(c == len));
            if (c == rst_clk) begin
                rst = 1'b1;
                @(negedge clk);
                chk(tg(k, c, "rst_tx"),    32'(tx_w[k]),    32'd1);
                chk(tg(k, c, "rst_busy"),  32'(busy_w[k]),  32'd0);
                chk(tg(k, c, "rst_done"),  32'(done_w[k]),  32'd0);
                chk(tg(k, c, "rst_ready"), 32'(ready_w[k]), 32'd0);
                rst = 1'b0;
                #1;
                chk(tg(k, c, "ready_after_release"), 32'(ready_w[k]), 32'd1);
                $display("frame k%0d data=%0h aborted by reset at clock %0d", k, d, c);
                return;
            end
            if (c == noise_clk) begin
                valid_r[k] = 1'b1;
                data_r[k]  = 9'h1FF;
            end else if (c == noise_clk + 1) begin
                valid_r[k] = 1'b0;
            end
            if (c < len) @(negedge clk);
        end
        if (!chain) begin
            @(negedge clk);
            chk(tg(k, len + 1, "idle_tx"),    32'(tx_w[k]),    32'd1);
            chk(tg(k, len + 1, "idle_busy"),  32'(busy_w[k]),  32'd0);
            chk(tg(k, len + 1, "idle_done"),  32'(done_w[k]),  32'd0);
            chk(tg(k, len + 1, "idle_ready"), 32'(ready_w[k]), 32'd1);
        end
        $display("frame k%0d data=%0h len=%0d chained=%0d", k, d, len, chain);
    endtask

    initial begin
        logic [8:0] cur;
        logic [8:0] nxt;
        bit         ch;

        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            valid_r[k] = 1'b0;
            data_r[k]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk(tg(k, 0, "reset_tx"),    32'(tx_w[k]),    32'd1);
            chk(tg(k, 0, "reset_busy"),  32'(busy_w[k]),  32'd0);
            chk(tg(k, 0, "reset_done"),  32'(done_w[k]),  32'd0);
            chk(tg(k, 0, "reset_ready"), 32'(ready_w[k]), 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            chk(tg(k, 0, "release_ready"), 32'(ready_w[k]), 32'd1);
        end
        @(negedge clk);

        send(0, 9'h0A5, 1'b0, 9'h000, -1, -10);
        send(1, 9'h007, 1'b0, 9'h000, -1, -10);
        send(2, 9'h007, 1'b0, 9'h000, -1, -10);
        send(0, 9'h055, 1'b1, 9'h0AA, -1, -10);
        send(0, 9'h0AA, 1'b0, 9'h000, -1, -10);
        send(3, 9'h041, 1'b0, 9'h000, -1, -10);
        send(0, 9'($urandom), 1'b0, 9'h000, 4 * CD[0] + 1, -10);
        @(negedge clk);
        send(0, 9'h0C3, 1'b0, 9'h000, -1, 10);

        for (int k = 0; k < N; k++) begin
            cur = 9'($urandom);
            for (int i = 0; i < 4; i++) begin
                nxt = 9'($urandom);
                ch  = (i < 3) && ($urandom_range(1) == 1);
                send(k, cur, ch, nxt, -1, -10);
                cur = nxt;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
